seq_detector_param: RTL

Parametrised serial pattern detector: the next generation of the fixed 3-bit-state sequence-detector FSM. It watches a one-bit serial stream `x` and flags every occurrence of an N-bit pattern, with the following additions:
- runtime-loadable pattern;
- overlap / non-overlap mode;
- input qualifier;
- saturating match counter.

Current and next state stay exposed as `cs`/`ns` for waveform-based checking in the lab benches.

---
 rtl/seq_detector_param_if.sv | 29 ++
 rtl/seq_detector_param.sv | 106 ++++++++++
 2 files changed

// File: rtl/seq_detector_param_if.sv
// Bundles the serial-stream, pattern, counter and observation signals of seq_detector_param.
// The master modport is the stimulus side; the slave modport is the detector.
interface seq_detector_param_if #(
    parameter int N     = 6,
    parameter int CNT_W = 8
);
    localparam int STATE_W = $clog2(N + 1);

    logic               x;
    logic               x_en;
    logic               overlap;
    logic               pat_load;
    logic [N-1:0]       pat_in;
    logic               cnt_clr;
    logic               y;
    logic [STATE_W-1:0] cs;
    logic [STATE_W-1:0] ns;
    logic [CNT_W-1:0]   match_cnt;

    modport master (
        output x, x_en, overlap, pat_load, pat_in, cnt_clr,
        input  y, cs, ns, match_cnt
    );

    modport slave (
        input  x, x_en, overlap, pat_load, pat_in, cnt_clr,
        output y, cs, ns, match_cnt
    );
endinterface

// File: rtl/seq_detector_param.sv
// KMP-style serial pattern detector with loadable pattern, overlap mode and saturating count.
// Define SEQDET_MOORE_EN for a registered (Moore) y; the default build drives y combinationally.
module seq_detector_param #(
    parameter int           N             = 6,
    parameter logic [N-1:0] RESET_PATTERN = 6'b101101,
    parameter int           CNT_W         = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    seq_detector_param_if.slave  bus
);
    localparam int STATE_W = $clog2(N + 1);
    localparam logic [STATE_W-1:0] S_IDLE = '0;
    localparam logic [STATE_W-1:0] S_FULL = STATE_W'(N);

    logic [N-1:0]       pat;
    logic [STATE_W-1:0] cs_q;
    logic [STATE_W-1:0] ce;
    logic [STATE_W-1:0] ns;
    logic [CNT_W-1:0]   cnt_q;
    logic               match;

    // Longest prefix of p_pat that is a suffix of (p_pat prefix of length st, then xb).
    function automatic logic [STATE_W-1:0] kmp_next(
        input logic [N-1:0]       p_pat,
        input logic [STATE_W-1:0] st,
        input logic               xb
    );
        int         c;
        int         best;
        int         i;
        logic       ok;
        logic       pre_b;
        logic       str_b;
        logic [N-1:0] sh;
        c    = int'(st);
        best = 0;
        for (int k = 1; k <= N; k++) begin
            if (k <= c + 1) begin
                ok = 1'b1;
                for (int j = 0; j < N; j++) begin
                    if (j < k) begin
                        sh    = p_pat >> (N - 1 - j);
                        pre_b = sh[0];
                        i     = c + 1 - k + j;
                        if (i == c) begin
                            str_b = xb;
                        end else begin
                            sh    = p_pat >> (N - 1 - i);
                            str_b = sh[0];
                        end
                        if (pre_b != str_b) ok = 1'b0;
                    end
                end
                if (ok) best = k;
            end
        end
        return STATE_W'(best);
    endfunction

    always_comb begin
        ce = cs_q;
        if (cs_q == S_FULL && !bus.overlap) ce = S_IDLE;
        ns = bus.x_en ? kmp_next(pat, ce, bus.x) : cs_q;
    end

    assign match        = bus.x_en & ~bus.pat_load & (ns == S_FULL);
    assign bus.ns        = ns;
    assign bus.cs        = cs_q;
    assign bus.match_cnt = cnt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            pat   <= RESET_PATTERN;
            cs_q  <= S_IDLE;
            cnt_q <= '0;
        end else begin
            // A load restarts the search and discards the bit presented with it.
            if (bus.pat_load) begin
                pat  <= bus.pat_in;
                cs_q <= S_IDLE;
            end else if (bus.x_en) begin
                cs_q <= ns;
            end
            if (bus.cnt_clr) begin
                cnt_q <= '0;
            end else if (match && !(&cnt_q)) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

`ifdef SEQDET_MOORE_EN
    logic y_p1;

    always_ff @(posedge clk) begin
        if (!rst) y_p1 <= 1'b0;
        else      y_p1 <= match;
    end

    assign bus.y = y_p1;
`else
    assign bus.y = match;
`endif

endmodule
